// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: five result sources, each with a small FIFO, share NUM_PORTS
// registered ROB writeback ports round-robin. Optional stall counter under WB_ARB_PERF_CNT_EN.
module wb_port_arbiter #(
    parameter int NUM_SRC    = 5,
    parameter int NUM_PORTS  = 2,
    parameter int TAG_W      = 4,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic [NUM_SRC-1:0]          src_valid,
    output logic [NUM_SRC-1:0]          src_ready,
    input  logic [NUM_SRC*TAG_W-1:0]    src_tag,
    input  logic [NUM_SRC*DATA_W-1:0]   src_data,
    output logic [NUM_PORTS-1:0]        wb_valid,
    output logic [NUM_PORTS*TAG_W-1:0]  wb_tag,
    output logic [NUM_PORTS*DATA_W-1:0] wb_data,
    output logic [NUM_PORTS*3-1:0]      wb_src
`ifdef WB_ARB_PERF_CNT_EN
    ,
    output logic [31:0]                 stall_cnt
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [TAG_W-1:0]  tag_mem_q  [NUM_SRC][FIFO_DEPTH];
    logic [DATA_W-1:0] data_mem_q [NUM_SRC][FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q   [NUM_SRC];
    logic [PTR_W-1:0]  rd_ptr_q   [NUM_SRC];
    logic [CNT_W-1:0]  cnt_q      [NUM_SRC];
    logic [2:0]        rr_q;
    logic [2:0]        rr_d;

    logic [NUM_PORTS-1:0]        wb_valid_q;
    logic [NUM_PORTS*TAG_W-1:0]  wb_tag_q;
    logic [NUM_PORTS*DATA_W-1:0] wb_data_q;
    logic [NUM_PORTS*3-1:0]      wb_src_q;

    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] pop;
    logic [NUM_SRC-1:0] nonempty;

    logic [NUM_PORTS-1:0] gnt_vld;
    logic [2:0]           gnt_src  [NUM_PORTS];
    logic [TAG_W-1:0]     gnt_tag  [NUM_PORTS];
    logic [DATA_W-1:0]    gnt_data [NUM_PORTS];
    logic [2:0]           last_gnt;
    int                   n_gnt;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (FIFO_DEPTH == 1) return '0;
        else                 return p + PTR_W'(1);
    endfunction

    // Ready looks only at the registered count, so a full FIFO never accepts
    // a push even when it is being popped in the same cycle.
    always_comb begin
        for (int s = 0; s < NUM_SRC; s++) begin
            src_ready[s] = (cnt_q[s] != CNT_W'(FIFO_DEPTH));
            nonempty[s]  = (cnt_q[s] != '0);
            push[s]      = src_valid[s] & src_ready[s] & ~flush;
        end
    end

    always_comb begin
        pop      = '0;
        gnt_vld  = '0;
        last_gnt = rr_q;
        n_gnt    = 0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            gnt_src[p]  = '0;
            gnt_tag[p]  = '0;
            gnt_data[p] = '0;
        end
        for (int k = 0; k < NUM_SRC; k++) begin
            for (int s = 0; s < NUM_SRC; s++) begin
                if (s == ((int'(rr_q) + k) % NUM_SRC) && nonempty[s] && n_gnt < NUM_PORTS) begin
                    pop[s] = 1'b1;
                    for (int p = 0; p < NUM_PORTS; p++) begin
                        if (p == n_gnt) begin
                            gnt_vld[p]  = 1'b1;
                            gnt_src[p]  = 3'(s);
                            gnt_tag[p]  = tag_mem_q[s][rd_ptr_q[s]];
                            gnt_data[p] = data_mem_q[s][rd_ptr_q[s]];
                        end
                    end
                    last_gnt = 3'(s);
                    n_gnt    = n_gnt + 1;
                end
            end
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (|gnt_vld) begin
            if (last_gnt == 3'(NUM_SRC - 1)) rr_d = '0;
            else                             rr_d = last_gnt + 3'd1;
        end
    end

    // Storage carries no reset; validity is tracked entirely by the counts.
    always_ff @(posedge clk) begin
        for (int s = 0; s < NUM_SRC; s++) begin
            if (push[s]) begin
                tag_mem_q[s][wr_ptr_q[s]]  <= src_tag[s*TAG_W +: TAG_W];
                data_mem_q[s][wr_ptr_q[s]] <= src_data[s*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < NUM_SRC; s++) begin
                cnt_q[s]    <= '0;
                wr_ptr_q[s] <= '0;
                rd_ptr_q[s] <= '0;
            end
            rr_q       <= '0;
            wb_valid_q <= '0;
            wb_tag_q   <= '0;
            wb_data_q  <= '0;
            wb_src_q   <= '0;
        end else if (flush) begin
            // Redirect: drop everything buffered, keep rr_q so fairness carries over.
            for (int s = 0; s < NUM_SRC; s++) begin
                cnt_q[s]    <= '0;
                wr_ptr_q[s] <= '0;
                rd_ptr_q[s] <= '0;
            end
            wb_valid_q <= '0;
        end else begin
            for (int s = 0; s < NUM_SRC; s++) begin
                if (push[s]) wr_ptr_q[s] <= ptr_inc(wr_ptr_q[s]);
                if (pop[s])  rd_ptr_q[s] <= ptr_inc(rd_ptr_q[s]);
                case ({push[s], pop[s]})
                    2'b10:   cnt_q[s] <= cnt_q[s] + CNT_W'(1);
                    2'b01:   cnt_q[s] <= cnt_q[s] - CNT_W'(1);
                    default: cnt_q[s] <= cnt_q[s];
                endcase
            end
            rr_q <= rr_d;
            for (int p = 0; p < NUM_PORTS; p++) begin
                wb_valid_q[p] <= gnt_vld[p];
                if (gnt_vld[p]) begin
                    wb_tag_q[p*TAG_W +: TAG_W]    <= gnt_tag[p];
                    wb_data_q[p*DATA_W +: DATA_W] <= gnt_data[p];
                    wb_src_q[p*3 +: 3]            <= gnt_src[p];
                end
            end
        end
    end

    assign wb_valid = wb_valid_q;
    assign wb_tag   = wb_tag_q;
    assign wb_data  = wb_data_q;
    assign wb_src   = wb_src_q;

`ifdef WB_ARB_PERF_CNT_EN
    logic [31:0] stall_cnt_q;

    // Counts cycles where some buffered head had to wait; flush does not clear it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else if (|(nonempty & ~pop) && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
